// File: rtl/ahb_rr_arbiter.sv
// Three-master AHB round-robin arbiter with a hold limit and a registered data-phase owner.
// Address-phase signals are muxed from HMASTER; HWDATA follows the owner of the previous accepted address phase.
module ahb_rr_arbiter #(
  parameter int NUM_M    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  HBUSREQ,
  input  logic [95:0] HADDR_M,
  input  logic [5:0]  HTRANS_M,
  input  logic [2:0]  HWRITE_M,
  input  logic [8:0]  HSIZE_M,
  input  logic [95:0] HWDATA_M,
  input  logic        HREADY,
  output logic [2:0]  HGRANT,
  output logic [1:0]  HMASTER,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA
);

  typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_e;

  localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  master_q, master_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  hold_q, hold_d;
  logic        dp_vld_q;
  logic [1:0]  dp_mst_q;

  logic [4:0]  hold_sum;
  logic        others_req;
  logic        any_req;
  logic        arb;
  logic [1:0]  cand1, cand2, win;

  function automatic logic [1:0] next_idx(input logic [1:0] m);
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  always_comb begin
    others_req = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (2'(i) != master_q && HBUSREQ[i]) others_req = 1'b1;
    end
    any_req = |HBUSREQ;

    // The limit counts the transfer accepted on this edge too, so the owner
    // gets exactly MAX_HOLD accepted transfers before yielding.
    hold_sum = {1'b0, hold_q} + {4'd0, (state_q == OWN) && HTRANS[1]};
    arb = HREADY && ((state_q == PARK) || !HBUSREQ[master_q] ||
                     ((hold_sum >= HOLD_LIM) && others_req));

    cand1 = next_idx(last_q);
    cand2 = next_idx(cand1);
    if (HBUSREQ[cand1])      win = cand1;
    else if (HBUSREQ[cand2]) win = cand2;
    else                     win = last_q;

    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    last_d   = last_q;
    hold_d   = hold_q;

    if (HREADY) begin
      hold_d = (hold_sum > 5'd15) ? 4'd15 : hold_sum[3:0];
      if (arb) begin
        if (any_req) begin
          state_d  = OWN;
          grant_d  = 3'b001 << win;
          master_d = win;
          last_d   = win;
          if (state_q == PARK || win != master_q) hold_d = 4'd0;
        end else begin
          state_d = PARK;
          grant_d = 3'b000;
          hold_d  = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= PARK;
      grant_q  <= 3'b000;
      master_q <= 2'd0;
      last_q   <= 2'd2;
      hold_q   <= 4'd0;
      dp_vld_q <= 1'b0;
      dp_mst_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      if (HREADY) begin
        dp_vld_q <= (state_q == OWN);
        dp_mst_q <= master_q;
      end
    end
  end

  assign HGRANT  = grant_q;
  assign HMASTER = master_q;

  always_comb begin
    HADDR  = 32'd0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    if (state_q == OWN) begin
      case (master_q)
        2'd0: begin
          HADDR  = HADDR_M[31:0];
          HTRANS = HTRANS_M[1:0];
          HWRITE = HWRITE_M[0];
          HSIZE  = HSIZE_M[2:0];
        end
        2'd1: begin
          HADDR  = HADDR_M[63:32];
          HTRANS = HTRANS_M[3:2];
          HWRITE = HWRITE_M[1];
          HSIZE  = HSIZE_M[5:3];
        end
        2'd2: begin
          HADDR  = HADDR_M[95:64];
          HTRANS = HTRANS_M[5:4];
          HWRITE = HWRITE_M[2];
          HSIZE  = HSIZE_M[8:6];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    HWDATA = 32'd0;
    if (dp_vld_q) begin
      case (dp_mst_q)
        2'd0:    HWDATA = HWDATA_M[31:0];
        2'd1:    HWDATA = HWDATA_M[63:32];
        2'd2:    HWDATA = HWDATA_M[95:64];
        default: HWDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ahb_rr_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  HBUSREQ;
  logic [95:0] HADDR_M;
  logic [5:0]  HTRANS_M;
  logic [2:0]  HWRITE_M;
  logic [8:0]  HSIZE_M;
  logic [95:0] HWDATA_M;
  logic        HREADY;
  logic [2:0]  HGRANT;
  logic [1:0]  HMASTER;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, who owned it last, accepted-transfer tally, data-phase owner.
  bit m_own;
  int m_master;
  int m_last;
  int m_hold;
  bit m_dpv;
  int m_dpm;

  ahb_rr_arbiter #(.NUM_M(3), .MAX_HOLD(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HADDR_M(HADDR_M),
    .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_own = 0; m_master = 0; m_last = 2; m_hold = 0; m_dpv = 0; m_dpm = 0;
  endtask

  task automatic model_step();
    int  acc, h, w;
    bit  others, arb, found;
    if (!HREADY) return;
    acc = (m_own && HTRANS_M[2*m_master+1]) ? 1 : 0;
    h = m_hold + acc;
    others = 0;
    for (int i = 0; i < 3; i++) if (i != m_master && HBUSREQ[i]) others = 1;
    arb = !m_own || !HBUSREQ[m_master] || (h >= 8 && others);
    if (h > 15) h = 15;
    m_dpv = m_own;
    m_dpm = m_master;
    if (arb) begin
      found = 0;
      w = 0;
      for (int j = 1; j <= 3; j++) begin
        if (!found && HBUSREQ[(m_last + j) % 3]) begin
          found = 1;
          w = (m_last + j) % 3;
        end
      end
      if (found) begin
        if (!m_own || w != m_master) h = 0;
        m_own = 1; m_master = w; m_last = w;
      end else begin
        m_own = 0; h = 0;
      end
    end
    m_hold = h;
  endtask

  task automatic model_out(output logic [2:0] g, output logic [1:0] mst, output logic [31:0] a,
                           output logic [1:0] t, output logic wr, output logic [2:0] s,
                           output logic [31:0] wd);
    g   = m_own ? 3'(1 << m_master) : 3'b000;
    mst = 2'(m_master);
    if (m_own) begin
      a  = HADDR_M[32*m_master +: 32];
      t  = HTRANS_M[2*m_master +: 2];
      wr = HWRITE_M[m_master];
      s  = HSIZE_M[3*m_master +: 3];
    end else begin
      a = 32'd0; t = 2'b00; wr = 1'b0; s = 3'b010;
    end
    wd = m_dpv ? HWDATA_M[32*m_dpm +: 32] : 32'd0;
  endtask

  task automatic cycle();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    HBUSREQ  = 3'b000;
    HADDR_M  = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010};
    HTRANS_M = 6'b000000;
    HWRITE_M = 3'b000;
    HSIZE_M  = {3'b010, 3'b001, 3'b000};
    HWDATA_M = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    HREADY   = 1'b1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    HTRANS_M = 6'b101010;
    HWRITE_M = 3'b111;
    HBUSREQ  = 3'b000;
    HRESETn  = 1'b0;
    model_reset();
    #1;
    vectors++; if (HGRANT !== 3'b000) begin miscompares++; $display("FAIL reset_hgrant: got %b expected 000", HGRANT); end
    vectors++; if (HMASTER !== 2'd0) begin miscompares++; $display("FAIL reset_hmaster: got %0d expected 0", HMASTER); end
    vectors++; if (HTRANS !== 2'b00) begin miscompares++; $display("FAIL reset_htrans: got %b expected 00", HTRANS); end
    vectors++; if (HSIZE !== 3'b010) begin miscompares++; $display("FAIL reset_hsize: got %b expected 010", HSIZE); end
    vectors++; if ({HADDR, HWRITE} !== 33'd0) begin miscompares++; $display("FAIL reset_haddr_hwrite: got %h/%b expected 0/0", HADDR, HWRITE); end
    vectors++; if (HWDATA !== 32'd0) begin miscompares++; $display("FAIL reset_hwdata: got %h expected 0", HWDATA); end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cycle();
    vectors++; if (HGRANT !== 3'b000) begin miscompares++; $display("FAIL park_no_req: got %b expected 000", HGRANT); end
  endtask

  task automatic test_first_grant();
    set_idle();
    do_reset();
    HTRANS_M = 6'b101010;
    HBUSREQ  = 3'b011;
    cycle();
    vectors++; if (HGRANT !== 3'b001) begin miscompares++; $display("FAIL first_grant: got %b expected 001", HGRANT); end
    vectors++; if (HMASTER !== 2'd0) begin miscompares++; $display("FAIL first_hmaster: got %0d expected 0", HMASTER); end
    vectors++; if (HADDR !== 32'h1000_0010) begin miscompares++; $display("FAIL first_haddr: got %h expected 10000010", HADDR); end
    HBUSREQ = 3'b010;
    cycle();
    vectors++; if (HGRANT !== 3'b010) begin miscompares++; $display("FAIL drop_m0_grant: got %b expected 010", HGRANT); end
    vectors++; if (HMASTER !== 2'd1) begin miscompares++; $display("FAIL drop_m0_hmaster: got %0d expected 1", HMASTER); end
  endtask

  task automatic test_rotation();
    logic [2:0] prev, want;
    int run, changes;
    set_idle();
    do_reset();
    HTRANS_M = 6'b101010;
    HBUSREQ  = 3'b111;
    cycle();
    vectors++; if (HGRANT !== 3'b001) begin miscompares++; $display("FAIL rot_start: got %b expected 001", HGRANT); end
    prev = HGRANT;
    run = 0;
    changes = 0;
    for (int k = 0; k < 60 && changes < 4; k++) begin
      cycle();
      run++;
      if (HGRANT !== prev) begin
        want = {prev[1:0], prev[2]};
        vectors++; if (HGRANT !== want) begin miscompares++; $display("FAIL rot_order: got %b expected %b", HGRANT, want); end
        vectors++; if (run !== 8) begin miscompares++; $display("FAIL rot_hold_len: got %0d expected 8", run); end
        prev = HGRANT;
        run = 0;
        changes++;
      end
    end
    vectors++; if (changes !== 4) begin miscompares++; $display("FAIL rot_timeout: got %0d grant changes expected 4", changes); end
  endtask

  task automatic test_hready_stall();
    set_idle();
    do_reset();
    HTRANS_M = 6'b101010;
    HBUSREQ  = 3'b010;
    cycle();
    vectors++; if (HGRANT !== 3'b010) begin miscompares++; $display("FAIL stall_setup: got %b expected 010", HGRANT); end
    HBUSREQ = 3'b101;
    HREADY  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      vectors++; if ({HGRANT, HMASTER} !== {3'b010, 2'd1}) begin miscompares++; $display("FAIL stall_hold: got %b/%0d expected 010/1", HGRANT, HMASTER); end
    end
    HREADY = 1'b1;
    cycle();
    vectors++; if (HGRANT !== 3'b100) begin miscompares++; $display("FAIL stall_release: got %b expected 100", HGRANT); end
  endtask

  task automatic test_write_handover();
    set_idle();
    do_reset();
    HADDR_M  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0004};
    HWRITE_M = 3'b001;
    HTRANS_M = 6'b100010;
    HWDATA_M = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    HBUSREQ  = 3'b001;
    cycle();
    vectors++; if ({HGRANT, HADDR, HWRITE} !== {3'b001, 32'h4, 1'b1}) begin miscompares++; $display("FAIL wr_addr_phase: got %b/%h/%b expected 001/00000004/1", HGRANT, HADDR, HWRITE); end
    vectors++; if (HWDATA !== 32'd0) begin miscompares++; $display("FAIL wr_no_dphase: got %h expected 0", HWDATA); end
    HBUSREQ = 3'b100;
    cycle();
    vectors++; if (HGRANT !== 3'b100) begin miscompares++; $display("FAIL wr_handover_grant: got %b expected 100", HGRANT); end
    vectors++; if (HWDATA !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_handover_hwdata: got %h expected deadbeef", HWDATA); end
    vectors++; if (HADDR !== 32'h0000_2000) begin miscompares++; $display("FAIL wr_handover_haddr: got %h expected 00002000", HADDR); end
    cycle();
    vectors++; if (HWDATA !== 32'h2222_2222) begin miscompares++; $display("FAIL wr_m2_dphase: got %h expected 22222222", HWDATA); end
  endtask

  task automatic test_saturate();
    set_idle();
    do_reset();
    HTRANS_M = 6'b100000;
    HBUSREQ  = 3'b100;
    cycle();
    vectors++; if (HGRANT !== 3'b100) begin miscompares++; $display("FAIL sat_setup: got %b expected 100", HGRANT); end
    for (int k = 0; k < 20; k++) begin
      cycle();
      vectors++; if (HGRANT !== 3'b100) begin miscompares++; $display("FAIL sat_hold_%0d: got %b expected 100", k, HGRANT); end
    end
    HBUSREQ = 3'b101;
    cycle();
    vectors++; if (HGRANT !== 3'b001) begin miscompares++; $display("FAIL sat_yield: got %b expected 001", HGRANT); end
  endtask

  task automatic test_reset_midxfer();
    set_idle();
    do_reset();
    HTRANS_M = 6'b001000;
    HBUSREQ  = 3'b010;
    cycle();
    vectors++; if ({HGRANT, HTRANS} !== {3'b010, 2'b10}) begin miscompares++; $display("FAIL midrst_setup: got %b/%b expected 010/10", HGRANT, HTRANS); end
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    vectors++; if ({HGRANT, HTRANS} !== {3'b000, 2'b00}) begin miscompares++; $display("FAIL midrst_async: got %b/%b expected 000/00", HGRANT, HTRANS); end
    @(posedge HCLK);
    #1;
    HBUSREQ = 3'b110;
    HRESETn = 1'b1;
    cycle();
    vectors++; if (HGRANT !== 3'b010) begin miscompares++; $display("FAIL midrst_regrant: got %b expected 010", HGRANT); end
  endtask

  task automatic test_random();
    logic [2:0]  eg;
    logic [1:0]  em;
    logic [31:0] ea, ewd;
    logic [1:0]  et;
    logic        ew;
    logic [2:0]  es;
    set_idle();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 3) HBUSREQ = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        HTRANS_M[2*i +: 2] = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
        HADDR_M[32*i +: 32]  = $urandom;
        HWDATA_M[32*i +: 32] = $urandom;
      end
      HWRITE_M = 3'($urandom_range(0, 7));
      HSIZE_M  = 9'($urandom_range(0, 511));
      HREADY   = ($urandom_range(0, 3) != 0);
      cycle();
      model_out(eg, em, ea, et, ew, es, ewd);
      vectors++;
      if ({HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE} !== {eg, em, ea, et, ew, es}) begin
        miscompares++;
        $display("FAIL rand_addr_%0d: got %b/%0d/%h/%b/%b/%b expected %b/%0d/%h/%b/%b/%b",
                 k, HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, eg, em, ea, et, ew, es);
      end
      vectors++;
      if (HWDATA !== ewd) begin
        miscompares++;
        $display("FAIL rand_hwdata_%0d: got %h expected %h", k, HWDATA, ewd);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_first_grant();
    test_rotation();
    test_hready_stall();
    test_write_handover();
    test_saturate();
    test_reset_midxfer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
